// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;

    // Quotient reported for a zero divisor: all ones at the native width.
    function automatic logic [DIV_WIDTH-1:0] dbz_quotient();
        return {DIV_WIDTH{1'b1}};
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: (WIDTH+1)-bit trial subtract of the divisor.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff_ext;
    logic [WIDTH:0]   picked;
    logic             borrow;
    logic             unused_msb;

    // The shifted-out remainder MSB lives in trial[WIDTH]; keeping it in the
    // subtract is what makes divisors above 2^(WIDTH-1) work.
    always_comb begin
        trial    = {rem_in, next_bit};
        diff_ext = {1'b0, trial} - {2'b00, divisor};
        borrow   = diff_ext[WIDTH+1];
        picked   = borrow ? trial : diff_ext[WIDTH:0];
    end

    // Remainder stays below the divisor, so the top bit of the pick is always 0.
    assign rem_out    = picked[WIDTH-1:0];
    assign unused_msb = picked[WIDTH];
    assign q_bit      = ~borrow;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for unsigned radix-2 restoring division, one step per clock.
// Latency: result WIDTH+1 cycles after accept; divide-by-zero 1 cycle after.
// Backpressure: result held in DONE until out_ready_i; in_ready_o follows out_ready_i there.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             dbz_o
);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic             dbz_reg;

    logic             accept;
    logic             load_calc;
    logic             load_dbz;
    logic             step;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

    // Ready in IDLE, or in DONE when the current result retires this cycle.
    // Reset and flush both block new work.
    assign in_ready_o = ~rst_i & ~flush_i &
                        ((state == IDLE) | ((state == DONE) & out_ready_i));
    assign accept     = in_valid_i & in_ready_o;

    assign busy_o      = (state == CALC);
    assign out_valid_o = (state == DONE);
    assign quotient_o  = q_reg;
    assign remainder_o = r_reg;
    assign dbz_o       = dbz_reg;

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in   (r_reg),
        .next_bit (q_reg[WIDTH-1]),
        .divisor  (d_reg),
        .rem_out  (rem_nxt),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes; a new accept overrides the retire path
    // so DONE can hand straight over to the next operation.
    always_comb begin
        state_nxt = state;
        load_calc = 1'b0;
        load_dbz  = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: ;
            CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            if (divisor_i == '0) begin
                state_nxt = DONE;
                load_dbz  = 1'b1;
            end else begin
                state_nxt = CALC;
                load_calc = 1'b1;
            end
        end
        if (flush_i) begin
            state_nxt = IDLE;
            step      = 1'b0;
        end
    end

    // Operand capture and the shifting remainder/quotient pair. Flush leaves
    // these untouched; out_valid_o is the only qualifier.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            d_reg   <= '0;
            r_reg   <= '0;
            q_reg   <= '0;
            dbz_reg <= 1'b0;
        end else if (load_calc) begin
            cnt     <= CNT_W'(WIDTH);
            d_reg   <= divisor_i;
            r_reg   <= '0;
            q_reg   <= dividend_i;
            dbz_reg <= 1'b0;
        end else if (load_dbz) begin
            cnt     <= '0;
            d_reg   <= divisor_i;
            r_reg   <= dividend_i;
            // WIDTH defaults to DIV_WIDTH, where this is exactly all ones.
            q_reg   <= WIDTH'(dbz_quotient());
            dbz_reg <= 1'b1;
        end else if (step) begin
            cnt     <= cnt - CNT_W'(1);
            r_reg   <= rem_nxt;
            q_reg   <= {q_reg[WIDTH-2:0], q_bit};
        end
    end

endmodule
